// File: rtl/ws2812b_frame_ctrl.sv
// Frame sequencer: streams NUM_LEDS GRB words from a sync-read pixel RAM into a ws2812b serializer.
// Optional macro WS2812B_FRAME_CTRL_AUTO_REFRESH_EN restarts the next frame right after each latch gap.
module ws2812b_frame_ctrl #(
  parameter int NUM_LEDS     = 64,
  parameter int BIT_CYCLES   = 15,
  parameter int RESET_CYCLES = 1000,
  parameter int ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] pix_addr_o,
  input  logic [23:0]       pix_data_i,
  input  logic              shift_i,
  output logic              serial_in_o,
  output logic              transmit_o
);

  localparam int CNT_MAX = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]     TAIL_LAST  = CW'(BIT_CYCLES - 3);
  localparam logic [CW-1:0]     LATCH_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LED_LAST   = ADDR_W'(NUM_LEDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_TAIL  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [23:0]       sreg_q, sreg_d;
  logic [23:0]       nxt_q, nxt_d;
  logic [4:0]        bit_q, bit_d;
  logic [ADDR_W-1:0] led_q, led_d;
  logic [CW-1:0]     ctr_q, ctr_d;
  logic [1:0]        pf_q, pf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_q, tx_d;
  logic              ser_q, ser_d;

  // Next-state logic; outputs are derived from the next state so they leave the flops glitch-free.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    led_d   = led_q;
    ctr_d   = ctr_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    pf_d    = {pf_q[0], 1'b0};

    // Prefetch pipe: address goes out one cycle, RAM data is valid the next.
    if (pf_q[1]) begin
      nxt_d = pix_data_i;
    end else begin
      nxt_d = nxt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          ctr_d   = '0;
          addr_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (ctr_q == '0) begin
          ctr_d = CW'(1);
        end else begin
          sreg_d  = pix_data_i;
          bit_d   = 5'd23;
          led_d   = '0;
          ctr_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (shift_i) begin
          if (bit_q != 5'd0) begin
            sreg_d = {sreg_q[22:0], 1'b0};
            bit_d  = bit_q - 5'd1;
            if ((bit_q == 5'd23) && (led_q != LED_LAST)) begin
              addr_d  = led_q + ADDR_W'(1);
              pf_d[0] = 1'b1;
            end else begin
              addr_d = addr_q;
            end
          end else if (led_q != LED_LAST) begin
            sreg_d = nxt_q;
            bit_d  = 5'd23;
            led_d  = led_q + ADDR_W'(1);
          end else begin
            state_d = S_TAIL;
            ctr_d   = TAIL_LAST;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_TAIL: begin
        if (ctr_q == '0) begin
          state_d = S_LATCH;
          ctr_d   = LATCH_LAST;
        end else begin
          ctr_d = ctr_q - CW'(1);
        end
      end
      S_LATCH: begin
        if (ctr_q == '0) begin
          done_d = 1'b1;
          bit_d  = 5'd0;
          led_d  = '0;
`ifdef WS2812B_FRAME_CTRL_AUTO_REFRESH_EN
          state_d = S_FETCH;
          addr_d  = '0;
`else
          state_d = S_IDLE;
`endif
        end else begin
          ctr_d = ctr_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ctr_d   = '0;
      end
    endcase

    tx_d   = (state_d == S_SEND) || (state_d == S_TAIL);
    busy_d = (state_d != S_IDLE);
    if (tx_d) begin
      ser_d = sreg_d[23];
    end else begin
      ser_d = 1'b0;
    end
  end

  // State and output registers; reset drops transmit and serial_in without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sreg_q  <= 24'h000000;
      nxt_q   <= 24'h000000;
      bit_q   <= 5'd0;
      led_q   <= '0;
      ctr_q   <= '0;
      pf_q    <= 2'b00;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      nxt_q   <= nxt_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      ctr_q   <= ctr_d;
      pf_q    <= pf_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      ser_q   <= ser_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pix_addr_o  = addr_q;
  assign serial_in_o = ser_q;
  assign transmit_o  = tx_q;

endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// Scoreboard bench for ws2812b_frame_ctrl: a pixel-RAM model and a bit-period serializer model
// feed the DUT; expected bit streams and frame timing come from plain arithmetic on the RAM contents.
module tb_ws2812b_frame_ctrl;

  localparam int NL        = 3;
  localparam int BC        = 15;
  localparam int RC        = 20;
  localparam int AW        = 2;
  localparam int FRAME_CYC = NL * 24 * BC;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          shift;
  logic [23:0]   pix_data;
  logic          busy;
  logic          done;
  logic          serial_in;
  logic          transmit;
  logic [AW-1:0] pix_addr;

  logic [23:0] mem [4];
  int          n_chk;
  int          n_fail;
  int          cyc;
  int          done_cnt;
  int          bits_seen;
  bit          spur_en;
  bit          exp_bits[$];
  int          exp_rise[$];

  ws2812b_frame_ctrl #(.NUM_LEDS(NL), .BIT_CYCLES(BC), .RESET_CYCLES(RC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .busy_o     (busy),
    .done_o     (done),
    .pix_addr_o (pix_addr),
    .pix_data_i (pix_data),
    .shift_i    (shift),
    .serial_in_o(serial_in),
    .transmit_o (transmit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read pixel RAM
  always @(posedge clk) pix_data <= mem[pix_addr];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Reference model: a frame is every LED word, MSB first, in address order.
  task automatic push_frame(input int rise_at);
    exp_rise.push_back(rise_at);
    for (int k = 0; k < NL; k++) begin
      for (int b = 23; b >= 0; b--) begin
        exp_bits.push_back(mem[k][b]);
      end
    end
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < FRAME_CYC + RC + 100) begin
      tick();
      n++;
    end
    check(name, done_cnt - d0, 1);
  endtask

  task automatic run_frame();
    start = 1'b1;
    push_frame(cyc + 3);
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("addr_zero_fetch", int'(pix_addr), 0);
    wait_done("frame_done");
  endtask

  task automatic randomize_mem();
    for (int k = 0; k < NL; k++) begin
      mem[k] = 24'($urandom);
    end
  endtask

  // Serializer model: shift pulses one cycle into every BC-cycle bit period while transmit is high.
  initial begin : serializer
    int ph;
    bit ptx;
    ph    = 0;
    ptx   = 1'b0;
    shift = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (transmit) begin
        ph    = ptx ? (ph + 1) % BC : 0;
        shift = (ph == 1);
      end else begin
        ph    = 0;
        shift = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      ptx = transmit;
    end
  end

  // Monitor: pops the scoreboard on every latched bit and checks frame/latch timing.
  initial begin : monitor
    bit ptx;
    bit pser;
    bit pshift;
    bit in_latch;
    bit chk_addr;
    int rise_c;
    int fall_c;
    int exp_addr;
    ptx = 1'b0; pser = 1'b0; pshift = 1'b0; in_latch = 1'b0; chk_addr = 1'b0;
    rise_c = 0; fall_c = 0; exp_addr = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        exp_bits.delete();
        exp_rise.delete();
        ptx = 1'b0; pser = 1'b0; pshift = 1'b0; in_latch = 1'b0; chk_addr = 1'b0;
        bits_seen = 0;
      end else begin
        if (chk_addr) begin
          check("prefetch_addr", int'(pix_addr), exp_addr);
          chk_addr = 1'b0;
        end
        if (transmit && !ptx) begin
          rise_c    = cyc;
          bits_seen = 0;
          if (exp_rise.size() == 0) check("unexpected_frame", 1, 0);
          else check("rise_cycle", cyc, exp_rise.pop_front());
        end
        if (!transmit && ptx) begin
          check("tx_len", cyc - rise_c, FRAME_CYC);
          check("bits_left", exp_bits.size(), 0);
          fall_c   = cyc;
          in_latch = 1'b1;
        end
        if (transmit && ptx && (serial_in != pser)) check("ser_change_after_shift", int'(pshift), 1);
        if (!transmit && shift) check("ser_low_outside_frame", int'(serial_in), 0);
        if (transmit && shift) begin
          if ((bits_seen % 24 == 0) && (bits_seen / 24 < NL - 1)) begin
            chk_addr = 1'b1;
            exp_addr = bits_seen / 24 + 1;
          end
          if (exp_bits.size() == 0) check("extra_bit", 1, 0);
          else check($sformatf("bit%0d", bits_seen), int'(serial_in), int'(exp_bits.pop_front()));
          bits_seen++;
        end
        if (done) begin
          done_cnt++;
          check("done_after_latch", int'(in_latch), 1);
          check("done_gap", cyc - fall_c, RC);
`ifdef WS2812B_FRAME_CTRL_AUTO_REFRESH_EN
          check("busy_at_done", int'(busy), 1);
`else
          check("busy_at_done", int'(busy), 0);
`endif
          in_latch = 1'b0;
        end
        ptx    = transmit;
        pser   = serial_in;
        pshift = shift;
      end
    end
  end

  initial begin : stim
    int d0;
    int n;
    n_chk = 0; n_fail = 0; cyc = 0; done_cnt = 0; bits_seen = 0;
    rst_n = 1'b0; start = 1'b0; spur_en = 1'b0;
    mem[3] = 24'h000000;
    randomize_mem();
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_transmit", int'(transmit), 0);
    check("rst_serial_in", int'(serial_in), 0);
    check("rst_pix_addr", int'(pix_addr), 0);
    rst_n = 1'b1;
    tick();
`ifdef WS2812B_FRAME_CTRL_AUTO_REFRESH_EN
    start = 1'b1;
    push_frame(cyc + 3);
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    for (int f = 0; f < 3; f++) begin
      wait_done("auto_done");
      randomize_mem();
      push_frame(cyc + 2);
    end
    repeat (100) tick();
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1 check("auto_rst_transmit", int'(transmit), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (FRAME_CYC + RC + 20) tick();
    check("auto_stopped_busy", int'(busy), 0);
    check("auto_no_done_after_reset", done_cnt - d0, 0);
`else
    // Spurious shifts while idle, then through FETCH and LATCH of the first frame
    spur_en = 1'b1;
    repeat (30) tick();
    check("idle_spur_busy", int'(busy), 0);
    check("idle_spur_transmit", int'(transmit), 0);
    check("idle_spur_addr", int'(pix_addr), 0);
    mem[0] = 24'hA5A5A5;
    mem[1] = 24'h5A5A5A;
    mem[2] = 24'h00FF81;
    run_frame();
    spur_en = 1'b0;

    for (int f = 0; f < 3; f++) begin
      randomize_mem();
      repeat ($urandom_range(0, 3)) tick();
      run_frame();
    end

    // start held high: ignored while busy, accepted again in the done cycle
    randomize_mem();
    start = 1'b1;
    push_frame(cyc + 3);
    wait_done("held_done1");
    push_frame(cyc + 3);
    wait_done("held_done2");
    start = 1'b0;
    repeat (10) tick();
    check("held_no_third_frame", int'(busy), 0);

    // Reset while LED1 bit 10 is on the line
    randomize_mem();
    start = 1'b1;
    push_frame(cyc + 3);
    tick();
    start = 1'b0;
    n = 0;
    while (bits_seen != 38 && n < FRAME_CYC) begin
      tick();
      n++;
    end
    check("reset_point_reached", bits_seen, 38);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_transmit", int'(transmit), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_serial_in", int'(serial_in), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (FRAME_CYC + RC + 20) tick();
    check("no_done_after_reset", done_cnt - d0, 0);
    randomize_mem();
    run_frame();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
